// File: rtl/micro_op_queue_pkg.sv
// Shared micro-op field widths, the packed micro-op record, and its all-zero NOP value.
// The queue stores records of this type, and decode treats a zero record as a bubble.
package micro_op_queue_pkg;

    localparam int MICRO_W    = 8;
    localparam int REG_ADDR_W = 4;
    localparam int IMM_W      = 32;
    localparam int BIT_MODE_W = 2;
    localparam int ADDR_W     = 64;

    typedef struct packed {
        logic [MICRO_W-1:0]    opcode;
        logic [REG_ADDR_W-1:0] reg_addr_d;
        logic [REG_ADDR_W-1:0] reg_addr_s;
        logic [REG_ADDR_W-1:0] reg_addr_t;
        logic [IMM_W-1:0]      immediate;
        logic [BIT_MODE_W-1:0] bit_mode;
        logic                  efl_mode;
        logic [ADDR_W-1:0]     pc;
    } micro_op_t;

    localparam micro_op_t MICRO_OP_NOP = '0;

endpackage

// File: rtl/micro_op_queue_ctrl.sv
// Pointer and occupancy bookkeeping for the micro-op queue.
// Generates the qualified push/pop strobes and the full/empty flags.
module micro_op_queue_ctrl
    import micro_op_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enqValid,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic [PTR_W-1:0] o_rdPtr,
    output logic [PTR_W-1:0] o_wrPtr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_push,
    output logic             o_pop,
    output logic             o_full,
    output logic             o_empty
);

    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;

    // A full queue refuses the offer even when a pop is also happening this cycle.
    always_comb begin
        o_full  = (r_count == CNT_W'(DEPTH));
        o_empty = (r_count == '0);
        o_push  = i_enqValid & ~o_full & ~i_flush & ~i_rst;
        o_pop   = ~o_empty & ~i_stall & ~i_flush & ~i_rst;
    end

    // Flush behaves like reset for the bookkeeping so the redirect starts from slot 0.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (o_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (o_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            r_count <= r_count + CNT_W'(o_push) - CNT_W'(o_pop);
        end
    end

    assign o_rdPtr = r_rdPtr;
    assign o_wrPtr = r_wrPtr;
    assign o_count = r_count;

endmodule

// File: rtl/micro_op_queue.sv
// Circular FIFO of decoded micro-ops feeding decode_phase.
// The oldest entry is driven combinationally, and an empty queue presents a NOP.
module micro_op_queue
    import micro_op_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enq_valid,
    output logic                  o_enq_ready,
    input  logic [MICRO_W-1:0]    i_enq_opcode,
    input  logic [REG_ADDR_W-1:0] i_enq_reg_addr_d,
    input  logic [REG_ADDR_W-1:0] i_enq_reg_addr_s,
    input  logic [REG_ADDR_W-1:0] i_enq_reg_addr_t,
    input  logic [IMM_W-1:0]      i_enq_immediate,
    input  logic [BIT_MODE_W-1:0] i_enq_bit_mode,
    input  logic                  i_enq_efl_mode,
    input  logic [ADDR_W-1:0]     i_enq_pc,
    output logic [MICRO_W-1:0]    o_deq_opcode_head,
    output logic [REG_ADDR_W-1:0] o_deq_reg_addr_d_head,
    output logic [REG_ADDR_W-1:0] o_deq_reg_addr_s_head,
    output logic [REG_ADDR_W-1:0] o_deq_reg_addr_t_head,
    output logic [IMM_W-1:0]      o_deq_immediate_head,
    output logic [BIT_MODE_W-1:0] o_deq_bit_mode_head,
    output logic                  o_deq_efl_mode_head,
    output logic [ADDR_W-1:0]     o_deq_pc_head,
    output logic                  o_deq_valid,
    input  logic                  i_stall,
    input  logic                  i_flush,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    micro_op_t        r_mem [DEPTH];
    micro_op_t        w_enqEntry;
    micro_op_t        w_head;
    logic [PTR_W-1:0] w_rdPtr;
    logic [PTR_W-1:0] w_wrPtr;
    logic [CNT_W-1:0] w_count;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    micro_op_queue_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_enqValid (i_enq_valid),
        .i_stall    (i_stall),
        .i_flush    (i_flush),
        .o_rdPtr    (w_rdPtr),
        .o_wrPtr    (w_wrPtr),
        .o_count    (w_count),
        .o_push     (w_push),
        .o_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign w_enqEntry = '{
        opcode:     i_enq_opcode,
        reg_addr_d: i_enq_reg_addr_d,
        reg_addr_s: i_enq_reg_addr_s,
        reg_addr_t: i_enq_reg_addr_t,
        immediate:  i_enq_immediate,
        bit_mode:   i_enq_bit_mode,
        efl_mode:   i_enq_efl_mode,
        pc:         i_enq_pc
    };

    // Storage carries no reset; the empty-forcing below hides whatever it holds.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[w_wrPtr] <= w_enqEntry;
    end

    assign w_head = w_empty ? MICRO_OP_NOP : r_mem[w_rdPtr];

    assign o_deq_opcode_head     = w_head.opcode;
    assign o_deq_reg_addr_d_head = w_head.reg_addr_d;
    assign o_deq_reg_addr_s_head = w_head.reg_addr_s;
    assign o_deq_reg_addr_t_head = w_head.reg_addr_t;
    assign o_deq_immediate_head  = w_head.immediate;
    assign o_deq_bit_mode_head   = w_head.bit_mode;
    assign o_deq_efl_mode_head   = w_head.efl_mode;
    assign o_deq_pc_head         = w_head.pc;
    assign o_deq_valid           = ~w_empty;
    assign o_enq_ready           = ~w_full;
    assign o_count               = w_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (w_count <= CNT_W'(DEPTH));
            assert (!(w_push && w_full));
            assert ((w_count != '0) || (w_head == MICRO_OP_NOP));
        end
    end

    logic w_unusedPop;
    assign w_unusedPop = w_pop;

endmodule

// File: tb/tb_micro_op_queue.sv
// Directed bench for micro_op_queue with a reference occupancy model and a scoreboard.
// Every cycle the head, count and handshake flags are checked against the expected queue.
module tb_micro_op_queue;
    import micro_op_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enqValid;
    logic                  enqReady;
    logic [MICRO_W-1:0]    enqOpcode;
    logic [REG_ADDR_W-1:0] enqRegD;
    logic [REG_ADDR_W-1:0] enqRegS;
    logic [REG_ADDR_W-1:0] enqRegT;
    logic [IMM_W-1:0]      enqImm;
    logic [BIT_MODE_W-1:0] enqBitMode;
    logic                  enqEflMode;
    logic [ADDR_W-1:0]     enqPc;
    logic [MICRO_W-1:0]    headOpcode;
    logic [REG_ADDR_W-1:0] headRegD;
    logic [REG_ADDR_W-1:0] headRegS;
    logic [REG_ADDR_W-1:0] headRegT;
    logic [IMM_W-1:0]      headImm;
    logic [BIT_MODE_W-1:0] headBitMode;
    logic                  headEflMode;
    logic [ADDR_W-1:0]     headPc;
    logic                  deqValid;
    logic                  stall;
    logic                  flush;
    logic [CNT_W-1:0]      count;

    micro_op_t sbQ [$];
    int        modelCount = 0;
    int        total = 0;
    int        bad = 0;

    always #5 clk = ~clk;

    micro_op_queue #(.DEPTH(DEPTH)) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_enq_valid           (enqValid),
        .o_enq_ready           (enqReady),
        .i_enq_opcode          (enqOpcode),
        .i_enq_reg_addr_d      (enqRegD),
        .i_enq_reg_addr_s      (enqRegS),
        .i_enq_reg_addr_t      (enqRegT),
        .i_enq_immediate       (enqImm),
        .i_enq_bit_mode        (enqBitMode),
        .i_enq_efl_mode        (enqEflMode),
        .i_enq_pc              (enqPc),
        .o_deq_opcode_head     (headOpcode),
        .o_deq_reg_addr_d_head (headRegD),
        .o_deq_reg_addr_s_head (headRegS),
        .o_deq_reg_addr_t_head (headRegT),
        .o_deq_immediate_head  (headImm),
        .o_deq_bit_mode_head   (headBitMode),
        .o_deq_efl_mode_head   (headEflMode),
        .o_deq_pc_head         (headPc),
        .o_deq_valid           (deqValid),
        .i_stall               (stall),
        .i_flush               (flush),
        .o_count               (count)
    );

    // Compares one observed value against its expected value and records the outcome.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Checks every visible output against the model after the clock edge has settled.
    task automatic checkState(input string tag);
        micro_op_t headObs;
        micro_op_t headExp;
        headObs = '{opcode: headOpcode, reg_addr_d: headRegD, reg_addr_s: headRegS,
                    reg_addr_t: headRegT, immediate: headImm, bit_mode: headBitMode,
                    efl_mode: headEflMode, pc: headPc};
        headExp = (sbQ.size() == 0) ? MICRO_OP_NOP : sbQ[0];
        checkOutput({tag, ".count"}, 128'(count), 128'(modelCount));
        checkOutput({tag, ".deqValid"}, 128'(deqValid), 128'(modelCount != 0));
        checkOutput({tag, ".enqReady"}, 128'(enqReady), 128'(modelCount < DEPTH));
        checkOutput({tag, ".head"}, 128'(headObs), 128'(headExp));
    endtask

    // Drives one cycle of inputs, updates the model and scoreboard, then checks the result.
    task automatic applyStimulus(input string tag, input logic v, input logic [MICRO_W-1:0] op,
                                 input logic [ADDR_W-1:0] pc, input logic st,
                                 input logic fl, input logic rs);
        micro_op_t entry;
        bit        doPush;
        bit        doPop;
        rst        = rs;
        flush      = fl;
        stall      = st;
        enqValid   = v;
        enqOpcode  = op;
        enqRegD    = op[3:0];
        enqRegS    = ~op[3:0];
        enqRegT    = op[7:4];
        enqImm     = {op, 24'hC0FFEE} ^ 32'(pc);
        enqBitMode = op[1:0];
        enqEflMode = op[0];
        enqPc      = pc;
        entry = '{opcode: enqOpcode, reg_addr_d: enqRegD, reg_addr_s: enqRegS,
                  reg_addr_t: enqRegT, immediate: enqImm, bit_mode: enqBitMode,
                  efl_mode: enqEflMode, pc: enqPc};
        doPush = v && (modelCount < DEPTH) && !fl && !rs;
        doPop  = (modelCount > 0) && !st && !fl && !rs;
        if (rs || fl) begin
            sbQ.delete();
            modelCount = 0;
        end else begin
            if (doPop) void'(sbQ.pop_front());
            if (doPush) sbQ.push_back(entry);
            modelCount = modelCount + int'(doPush) - int'(doPop);
        end
        @(posedge clk);
        #1;
        checkState(tag);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; enqValid = 1'b0;
        enqOpcode = '0; enqRegD = '0; enqRegS = '0; enqRegT = '0;
        enqImm = '0; enqBitMode = '0; enqEflMode = 1'b0; enqPc = '0;

        $display("[TB] reset");
        applyStimulus("rst0", 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus("rst1", 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus("idle", 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus("idleEmpty", 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] fill while stalled");
        for (int i = 1; i <= DEPTH; i++)
            applyStimulus("fill", 1'b1, 8'(i), 64'h1000 + 64'(i), 1'b1, 1'b0, 1'b0);
        applyStimulus("offer9", 1'b1, 8'h09, 64'h1009, 1'b1, 1'b0, 1'b0);
        checkOutput("fullHeadOpcode", 128'(headOpcode), 128'(1));

        $display("[TB] drain from full");
        applyStimulus("popWhileFullOffer", 1'b1, 8'h0A, 64'h100A, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus("drain", 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("drainedHeadOpcode", 128'(headOpcode), 128'(0));

        $display("[TB] steady push and pop across wraps");
        applyStimulus("prime", 1'b1, 8'h20, 64'h00FC, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            applyStimulus("steady", 1'b1, 8'(8'h21 + i), 64'h100 + 64'(4 * i), 1'b0, 1'b0, 1'b0);
        checkOutput("steadyLastPc", 128'(headPc), 128'(64'h100 + 64'(4 * 19)));
        applyStimulus("steadyDrain", 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] flush with enqueue offered");
        for (int i = 0; i < 5; i++)
            applyStimulus("preFlush", 1'b1, 8'(8'h40 + i), 64'h2000 + 64'(i), 1'b1, 1'b0, 1'b0);
        applyStimulus("flush", 1'b1, 8'h55, 64'h5555, 1'b0, 1'b1, 1'b0);
        checkOutput("flushHeadOpcode", 128'(headOpcode), 128'(0));
        applyStimulus("postFlushIdle", 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus("postFlushPush", 1'b1, 8'h66, 64'h6666, 1'b1, 1'b0, 1'b0);
        checkOutput("postFlushHeadOpcode", 128'(headOpcode), 128'(8'h66));

        $display("[TB] reset mid-stream");
        applyStimulus("preRst", 1'b1, 8'h70, 64'h7000, 1'b1, 1'b0, 1'b0);
        applyStimulus("preRst", 1'b1, 8'h71, 64'h7001, 1'b1, 1'b0, 1'b0);
        applyStimulus("midRst", 1'b1, 8'h72, 64'h7002, 1'b0, 1'b0, 1'b1);
        applyStimulus("postRstIdle", 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
